// File: rtl/janken_round_ctrl.sv
// rtl/janken_round_ctrl.sv - three-player janken round sequencer with debounced buttons
//
// Purpose: debounce the commit/start buttons, collect three 2-bit hands,
// run the jan-ken-pon countdown, judge the round and hold the result.
// Ports:
//   clk          system clock
//   rst_         synchronous active-low reset
//   gtp_         raw active-low commit-hand button (asynchronous)
//   start_       raw active-low start / next-round button (asynchronous)
//   hand_in      01 rock, 10 scissors, 11 paper, 00 no hand
//   player_sel   player currently prompted (0..2)
//   g_data       collected hands, [5:4] player 0, [3:2] player 1, [1:0] player 2
//   beat         countdown beat, 0 none, 1 jan, 2 ken, 3 pon
//   busy         high in COLLECT, COUNT and JUDGE
//   result_valid high in SHOW
//   winners      bit 2 player 0, bit 1 player 1, bit 0 player 2
//   aiko         tie round
module janken_round_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       gtp_,
  input  logic       start_,
  input  logic [1:0] hand_in,
  output logic [1:0] player_sel,
  output logic [5:0] g_data,
  output logic [1:0] beat,
  output logic       busy,
  output logic       result_valid,
  output logic [2:0] winners,
  output logic       aiko
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(COUNT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_COUNT   = 3'd2;
  localparam logic [2:0] ST_JUDGE   = 3'd3;
  localparam logic [2:0] ST_SHOW    = 3'd4;

  // Button conditioning: index 0 = gtp_, index 1 = start_.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;
  logic [1:0]    press;
  logic [DW-1:0] stab_cnt [2];

  assign raw = {start_, gtp_};

  always_ff @(posedge clk) begin
    if (!rst_) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      level <= 2'b11;
      press <= 2'b00;
      for (int i = 0; i < 2; i++) stab_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        // Any sample matching the accepted level restarts the stability run,
        // so chatter shorter than the debounce window never gets through.
        if (sync2[i] == level[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == DEB_LAST) begin
          stab_cnt[i] <= '0;
          level[i]    <= sync2[i];
          press[i]    <= ~sync2[i];
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic gtp_press;
  logic start_press;
  assign gtp_press   = press[0];
  assign start_press = press[1];

  // Round judgement on the collected hands.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b10) || (a == 2'b10 && b == 2'b11) ||
           (a == 2'b11 && b == 2'b01);
  endfunction

  logic [1:0] h0, h1, h2, other_hand, win_hand;
  logic       judge_tie;
  logic [2:0] judge_winners;

  always_comb begin
    h0 = g_data[5:4];
    h1 = g_data[3:2];
    h2 = g_data[1:0];
    judge_tie = (h0 == h1 && h1 == h2) || (h0 != h1 && h1 != h2 && h0 != h2);
    // Not a tie means exactly two distinct hands; find the one differing from player 0.
    other_hand = (h1 != h0) ? h1 : h2;
    win_hand   = beats(h0, other_hand) ? h0 : other_hand;
    judge_winners = judge_tie ? 3'b000 : {h0 == win_hand, h1 == win_hand, h2 == win_hand};
  end

  logic [2:0]    state;
  logic [CW-1:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      player_sel   <= 2'd0;
      g_data       <= 6'd0;
      beat         <= 2'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winners      <= 3'b000;
      aiko         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SHOW: begin
          if (state == ST_IDLE || start_press) begin
            g_data     <= 6'd0;
            player_sel <= 2'd0;
            winners    <= 3'b000;
            aiko       <= 1'b0;
          end
          if (start_press) begin
            state        <= ST_COLLECT;
            busy         <= 1'b1;
            result_valid <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (gtp_press && hand_in != 2'b00) begin
            g_data <= {g_data[3:0], hand_in};
            if (player_sel == 2'd2) begin
              player_sel <= 2'd0;
              state      <= ST_COUNT;
              beat       <= 2'd1;
              beat_cnt   <= '0;
            end else begin
              player_sel <= player_sel + 2'd1;
            end
          end
        end
        ST_COUNT: begin
          if (beat_cnt == CNT_LAST) begin
            beat_cnt <= '0;
            if (beat == 2'd3) begin
              beat  <= 2'd0;
              state <= ST_JUDGE;
            end else begin
              beat <= beat + 2'd1;
            end
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_JUDGE: begin
          winners      <= judge_winners;
          aiko         <= judge_tie;
          busy         <= 1'b0;
          result_valid <= 1'b1;
          state        <= ST_SHOW;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
